spi_master_param: RTL and testbench

// Parametrised full-duplex SPI master, the next generation of our 16-bit fixed-mode SPI block.

---
 rtl/spi_master_param.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_master_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable word width, SCLK divider, CPOL/CPHA and chip selects.
// Optional build macro SPI_LSB_FIRST_EN adds a per-transfer lsb_first input (MSB-first otherwise).
module spi_master_param #(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
  localparam logic [CS_W:0]     NUM_CS_L  = (CS_W + 1)'(NUM_CS);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_W);

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              lsb_in_s;
  logic              cs_ok_s;
  logic [NUM_CS-1:0] cs_dec_s;
  logic              div_last_s;
  logic              fire_s;
  logic [EDGE_W-1:0] edge_idx_s;
  logic [DATA_W-1:0] rx_shift_s;
  logic [DATA_W-1:0] tx_shift_s;
  logic              tx_next_s;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_in_s = lsb_first;
`else
  assign lsb_in_s = 1'b0;
`endif

  assign cs_ok_s    = ({1'b0, cs_sel} < NUM_CS_L);
  assign div_last_s = (div_q == DIV_LAST);

  // Shift helpers: direction follows the bit order latched at accept
  assign rx_shift_s = lsb_q ? {spi_miso, rx_sr_q[DATA_W-1:1]} : {rx_sr_q[DATA_W-2:0], spi_miso};
  assign tx_shift_s = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
  assign tx_next_s  = lsb_q ? tx_sr_q[0] : tx_sr_q[DATA_W-1];

  // One-hot active-low chip-select decode of the requested slave
  always_comb begin
    cs_dec_s = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) begin
        cs_dec_s[i] = 1'b0;
      end else begin
        cs_dec_s[i] = 1'b1;
      end
    end
  end

  // Next-state logic: FSM sequencing plus SCLK edge actions
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_d     = edge_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fire_s     = 1'b0;
    edge_idx_s = edge_q;

    case (state_q)
      ST_IDLE: begin
        sclk_d = cpol;
        if (start && cs_ok_s) begin
          state_d   = ST_SETUP;
          cpol_d    = cpol;
          cpha_d    = cpha;
          lsb_d     = lsb_in_s;
          cs_n_d    = cs_dec_s;
          mosi_d    = lsb_in_s ? tx_data[0] : tx_data[DATA_W-1];
          tx_sr_d   = lsb_in_s ? (tx_data >> 1) : (tx_data << 1);
          rx_sr_d   = '0;
          bit_cnt_d = CNT_FULL;
          busy_d    = 1'b1;
          div_d     = '0;
          edge_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_last_s) begin
          fire_s     = 1'b1;
          edge_idx_s = '0;
          div_d      = '0;
          state_d    = ST_SHIFT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT: begin
        if (div_last_s) begin
          fire_s = 1'b1;
          div_d  = '0;
          if (edge_q == EDGE_LAST) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HOLD: begin
        if (div_last_s) begin
          state_d   = ST_DONE;
          div_d     = '0;
          cs_n_d    = '1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          bit_cnt_d = CNT_FULL;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        cs_n_d    = '1;
        busy_d    = 1'b0;
        bit_cnt_d = CNT_FULL;
      end
    endcase

    // Even edge index = leading edge (away from cpol), odd = trailing edge
    if (fire_s) begin
      edge_d = edge_idx_s + EDGE_W'(1);
      if (edge_idx_s[0] == 1'b0) begin
        sclk_d = ~cpol_q;
        if (!cpha_q) begin
          rx_sr_d   = rx_shift_s;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else if (edge_idx_s != '0) begin
          mosi_d  = tx_next_s;
          tx_sr_d = tx_shift_s;
        end else begin
          mosi_d = mosi_q;
        end
      end else begin
        sclk_d = cpol_q;
        if (cpha_q) begin
          rx_sr_d   = rx_shift_s;
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else if (edge_idx_s != EDGE_LAST) begin
          mosi_d  = tx_next_s;
          tx_sr_d = tx_shift_s;
        end else begin
          mosi_d = mosi_q;
        end
      end
    end else begin
      edge_d = edge_d;
    end
  end

  // State and output registers; reset aborts any transfer silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= CNT_FULL;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_data  = rx_data_q;
  assign bit_cnt  = bit_cnt_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param (16-bit, CLK_DIV=2) with a behavioural SPI slave;
// a second 3-CS instance covers out-of-range slave selection.
module tb_spi_master_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, cpol, cpha, cs_sel;
  logic [15:0] tx_data;
  logic        busy, done, spi_sclk, spi_mosi;
  logic        spi_miso = 1'b0;
  logic [15:0] rx_data;
  logic [4:0]  bit_cnt;
  logic [1:0]  spi_cs_n;
`ifdef SPI_LSB_FIRST_EN
  logic        lsb_first = 1'b0;
`endif

  logic        start2;
  logic [1:0]  cs_sel2;
  logic        busy2, done2, sclk2, mosi2;
  logic [15:0] rx2;
  logic [4:0]  bc2;
  logic [2:0]  cs_n2;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] slave_word = 16'h0000;
  logic        tb_cpha = 1'b0;
  logic [15:0] mosi_cap = 16'h0000;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .busy(busy), .done(done), .rx_data(rx_data), .bit_cnt(bit_cnt),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  spi_master_param #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start2), .cpol(cpol), .cpha(cpha),
    .cs_sel(cs_sel2), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .busy(busy2), .done(done2), .rx_data(rx2), .bit_cnt(bc2),
    .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_miso(1'b0), .spi_cs_n(cs_n2)
  );

  // Behavioural slave: shifts slave_word out MSB-first and records mosi on its sample edges
  logic prev_cs = 1'b0;
  logic prev_sclk = 1'b0;
  int   ecnt = 0;
  always @(negedge clk) begin
    logic cs_act;
    int k;
    cs_act = (spi_cs_n != 2'b11);
    if (cs_act && !prev_cs) begin
      ecnt = 0;
      mosi_cap = 16'h0000;
      if (!tb_cpha) spi_miso = slave_word[15];
    end else if (cs_act && (spi_sclk != prev_sclk)) begin
      k = ecnt / 2;
      if ((ecnt % 2) == 0) begin
        if (!tb_cpha) mosi_cap = {mosi_cap[14:0], spi_mosi};
        else spi_miso = slave_word[15-k];
      end else begin
        if (tb_cpha) mosi_cap = {mosi_cap[14:0], spi_mosi};
        else if (k < 15) spi_miso = slave_word[14-k];
      end
      ecnt = ecnt + 1;
    end
    prev_cs = cs_act;
    prev_sclk = spi_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one transfer on dut; optionally pulses start mid-transfer with different inputs
  task automatic do_xfer(input logic cp, input logic ch, input logic cs, input logic [15:0] tx,
                         input logic [15:0] sw, input logic lsbv, input logic inj,
                         output int dcyc, output int csl, output int bsy,
                         output logic [1:0] csand, output logic dnext, output logic [4:0] bcd);
    @(negedge clk);
    cpol = cp; cpha = ch; slave_word = sw; tb_cpha = ch;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lsbv;
`else
    if (lsbv) $display("note: lsb_first requested without SPI_LSB_FIRST_EN");
`endif
    @(negedge clk);
    tx_data = tx; cs_sel = cs; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; tx_data = ~tx; cs_sel = ~cs; cpha = ~ch;
    dcyc = -1; csl = 0; bsy = 0; csand = 2'b11; bcd = 5'd0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (inj && c == 10) begin start = 1'b1; tx_data = 16'hDEAD; end
      if (inj && c == 11) start = 1'b0;
      if (spi_cs_n != 2'b11) csl++;
      if (busy) bsy++;
      csand = csand & spi_cs_n;
      if (done) begin dcyc = c; bcd = bit_cnt; break; end
    end
    @(negedge clk);
    dnext = done;
  endtask

  int dcyc, csl, bsy, cnt;
  logic [1:0] csand;
  logic dnext;
  logic [4:0] bcd;
  logic seen;

  initial begin
    reset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; cs_sel = 1'b0; tx_data = 16'h0000;
    start2 = 1'b0; cs_sel2 = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_idle_cs", 32'(spi_cs_n), 32'h3);
    chk("rst_idle_sclk", 32'(spi_sclk), 32'h0);
    chk("rst_idle_busy", 32'(busy), 32'h0);
    chk("rst_idle_done", 32'(done), 32'h0);
    chk("rst_idle_rx", 32'(rx_data), 32'h0);
    chk("rst_idle_bitcnt", 32'(bit_cnt), 32'd16);
    reset = 1'b0;
    @(negedge clk);

    // Reset during SETUP
    tx_data = 16'hA5C3; cs_sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("setup_cs", 32'(spi_cs_n), 32'h2);
    chk("setup_busy", 32'(busy), 32'h1);
    chk("setup_mosi", 32'(spi_mosi), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_setup_cs", 32'(spi_cs_n), 32'h3);
    chk("rst_setup_sclk", 32'(spi_sclk), 32'h0);
    chk("rst_setup_busy", 32'(busy), 32'h0);
    chk("rst_setup_done", 32'(done), 32'h0);
    chk("rst_setup_rx", 32'(rx_data), 32'h0);
    chk("rst_setup_bitcnt", 32'(bit_cnt), 32'd16);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Mode 0
    do_xfer(1'b0, 1'b0, 1'b0, 16'hA5C3, 16'h3C5A, 1'b0, 1'b0, dcyc, csl, bsy, csand, dnext, bcd);
    chk("m0_done_cyc", 32'(dcyc), 32'd67);
    chk("m0_cs_low", 32'(csl), 32'd66);
    chk("m0_busy", 32'(bsy), 32'd66);
    chk("m0_cs_which", 32'(csand), 32'h2);
    chk("m0_rx", 32'(rx_data), 32'h3C5A);
    chk("m0_mosi", 32'(mosi_cap), 32'hA5C3);
    chk("m0_done_pulse", 32'(dnext), 32'h0);
    chk("m0_bitcnt", 32'(bcd), 32'd16);

    // Mode 3: SCLK idles high
    cpol = 1'b1;
    repeat (2) @(negedge clk);
    chk("m3_sclk_idle", 32'(spi_sclk), 32'h1);
    do_xfer(1'b1, 1'b1, 1'b0, 16'h1234, 16'hFEDC, 1'b0, 1'b0, dcyc, csl, bsy, csand, dnext, bcd);
    chk("m3_done_cyc", 32'(dcyc), 32'd67);
    chk("m3_rx", 32'(rx_data), 32'hFEDC);
    chk("m3_mosi", 32'(mosi_cap), 32'h1234);
    chk("m3_sclk_after", 32'(spi_sclk), 32'h1);

    // cs_sel=1 with start pulsed while busy
    do_xfer(1'b0, 1'b0, 1'b1, 16'h5AF0, 16'h0F0F, 1'b0, 1'b1, dcyc, csl, bsy, csand, dnext, bcd);
    chk("cs1_which", 32'(csand), 32'h1);
    chk("cs1_done_cyc", 32'(dcyc), 32'd67);
    chk("cs1_rx", 32'(rx_data), 32'h0F0F);
    chk("cs1_mosi", 32'(mosi_cap), 32'h5AF0);
    chk("cs1_no_restart", 32'(busy), 32'h0);

    // Out-of-range slave index on the 3-CS instance is ignored; index 2 is accepted
    cs_sel2 = 2'd3; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy2 || cs_n2 != 3'b111) seen = 1'b1;
    end
    chk("cs3_ignored", 32'(seen), 32'h0);
    cs_sel2 = 2'd2; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    @(negedge clk);
    chk("cs2_low", 32'(cs_n2), 32'h3);
    cnt = -1;
    for (int c = 2; c <= 150; c++) begin
      @(negedge clk);
      if (done2) begin cnt = c; break; end
    end
    chk("cs2_done_cyc", 32'(cnt), 32'd67);

    // Reset after 7 samples aborts without done
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b1; tb_cpha = 1'b1; slave_word = 16'hAAAA;
    @(negedge clk);
    tx_data = 16'h00FF; cs_sel = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bit_cnt == 5'd9) begin seen = 1'b1; break; end
    end
    chk("abort_reached7", 32'(seen), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_cs", 32'(spi_cs_n), 32'h3);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_bitcnt", 32'(bit_cnt), 32'd16);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    do_xfer(1'b0, 1'b1, 1'b0, 16'h00FF, 16'hFF00, 1'b0, 1'b0, dcyc, csl, bsy, csand, dnext, bcd);
    chk("m1_done_cyc", 32'(dcyc), 32'd67);
    chk("m1_rx", 32'(rx_data), 32'hFF00);
    chk("m1_mosi", 32'(mosi_cap), 32'h00FF);

`ifdef SPI_LSB_FIRST_EN
    // LSB-first: tx bit 0 leaves first, first received bit lands in rx bit 0
    do_xfer(1'b0, 1'b0, 1'b0, 16'h0001, 16'h8000, 1'b1, 1'b0, dcyc, csl, bsy, csand, dnext, bcd);
    chk("lsb_first_mosi", 32'(mosi_cap[15]), 32'h1);
    chk("lsb_mosi_all", 32'(mosi_cap), 32'h8000);
    chk("lsb_rx", 32'(rx_data), 32'h0001);
    do_xfer(1'b0, 1'b0, 1'b0, 16'h0001, 16'h8000, 1'b0, 1'b0, dcyc, csl, bsy, csand, dnext, bcd);
    chk("msb_rx_again", 32'(rx_data), 32'h8000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
